// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the 4-bit PWM generator / duty meter pair.
// Keeping the defaults here means both ends of the link agree on the period.
package pwm_duty_meter_pkg;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_PERIOD = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } meter_state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// Input synchronizer for the asynchronous PWM line plus rising-edge detect.
// Only the synchronized level s is fit for use in the clk_i domain.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of a PWM waveform and recovers its duty value.
// Flags a line that stops toggling and any period that is off-nominal.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PERIOD      = DEF_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] duty_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             per_err_o
);
  localparam logic [CNT_W:0] PER_V = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0] SAT_V = (CNT_W+1)'(PERIOD + 1);
  localparam logic [CNT_W:0] ONE_V = (CNT_W+1)'(1);

  logic           s, rise;
  logic [CNT_W:0] per_cnt, hi_cnt;
  meter_state_t   state, state_n;
  logic [CNT_W-1:0] duty_n;
  logic           valid_n, per_err_n;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .reset (reset),
    .d     (pwm_i),
    .s     (s),
    .rise  (rise)
  );

  // The rise cycle is high and opens the new period, hence the reload to 1.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= ONE_V;
      hi_cnt  <= ONE_V;
    end else begin
      if (per_cnt != SAT_V)     per_cnt <= per_cnt + ONE_V;
      if (s && hi_cnt != SAT_V) hi_cnt  <= hi_cnt + ONE_V;
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      duty_o    <= '0;
      valid_o   <= 1'b0;
      per_err_o <= 1'b0;
      stuck_o   <= 1'b0;
    end else begin
      state     <= state_n;
      duty_o    <= duty_n;
      valid_o   <= valid_n;
      per_err_o <= per_err_n;
      stuck_o   <= (state_n == STUCK);
    end
  end

  // A rise takes priority over a timeout landing on the same cycle.
  always_comb begin
    state_n   = state;
    duty_n    = duty_o;
    valid_n   = 1'b0;
    per_err_n = 1'b0;
    if (rise) begin
      state_n = MEAS;
      if (state == MEAS) begin
        if (per_cnt == PER_V) begin
          duty_n  = hi_cnt[CNT_W-1:0];
          valid_n = 1'b1;
        end else begin
          per_err_n = 1'b1;
        end
      end
    end else if (state != STUCK && per_cnt == PER_V) begin
      state_n = STUCK;
      duty_n  = s ? '1 : '0;
      valid_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench: a waveform-level model predicts the publish/error event
// sequence; a monitor pops and compares whenever the meter emits an event.
module tb_pwm_duty_meter;
  localparam int CNT_W  = 4;
  localparam int PERIOD = 16;
  localparam int SYNC   = 2;

  logic             clk_i = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_i = 1'b0;
  logic [CNT_W-1:0] duty_o;
  logic             valid_o, stuck_o, per_err_o;

  pwm_duty_meter #(.CNT_W(CNT_W), .PERIOD(PERIOD), .SYNC_STAGES(SYNC)) dut (
    .clk_i     (clk_i),
    .reset     (reset),
    .pwm_i     (pwm_i),
    .duty_o    (duty_o),
    .valid_o   (valid_o),
    .stuck_o   (stuck_o),
    .per_err_o (per_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             err;
    logic [CNT_W-1:0] duty;
  } ev_t;

  ev_t exp_q[$];
  bit  wave[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string sc, input string what, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", sc, what, act, exp);
    end
  endtask

  // Synchronized level seen by the meter in cycle j after reset release.
  function automatic bit s_at(input int j);
    return (j >= SYNC) ? wave[j-SYNC] : 1'b0;
  endfunction

  // Split the synchronized waveform at its rising edges and judge each gap:
  // gap longer than PERIOD -> timeout publish; gap == PERIOD after a real
  // rise -> publish high-time; shorter gap after a real rise -> period error.
  task automatic model(output bit st, output int dty);
    int  rises[$];
    int  a;
    bit  measured;
    int  hi;
    for (int j = 0; j < wave.size(); j++)
      if (s_at(j) && !s_at(j-1)) rises.push_back(j);
    a = 0; measured = 1'b0; dty = 0;
    foreach (rises[k]) begin
      if (rises[k] - a > PERIOD) begin
        dty = s_at(a + PERIOD) ? 15 : 0;
        exp_q.push_back(ev_t'{1'b0, 4'(dty)});
      end else if (measured) begin
        if (rises[k] - a == PERIOD) begin
          hi = 0;
          for (int t = a; t < rises[k]; t++) hi += int'(s_at(t));
          dty = hi;
          exp_q.push_back(ev_t'{1'b0, 4'(dty)});
        end else begin
          exp_q.push_back(ev_t'{1'b1, 4'(dty)});
        end
      end
      measured = 1'b1;
      a = rises[k];
    end
    st = (wave.size() - 1 - a >= PERIOD);
    if (st) begin
      dty = s_at(a + PERIOD) ? 15 : 0;
      exp_q.push_back(ev_t'{1'b0, 4'(dty)});
    end
  endtask

  task automatic add_per(input int hi, input int len);
    for (int i = 0; i < len; i++) wave.push_back(i < hi);
  endtask

  task automatic add_const(input bit v, input int len);
    for (int i = 0; i < len; i++) wave.push_back(v);
  endtask

  // Drive the queued waveform from reset release, check end state, then
  // assert reset asynchronously between clock edges and check it clears all.
  task automatic run(input string sc, input int rst_dly);
    bit st;
    int d;
    model(st, d);
    reset = 1'b0;
    foreach (wave[i]) begin
      pwm_i = wave[i];
      @(negedge clk_i);
    end
    #1;
    check(sc, "events_left", exp_q.size(), 0);
    check(sc, "stuck_o", int'(stuck_o), int'(st));
    check(sc, "duty_o", int'(duty_o), d);
    exp_q.delete();
    #(rst_dly) reset = 1'b1;
    #1;
    check(sc, "rst_outs", int'({duty_o, valid_o, stuck_o, per_err_o}), 0);
    wave.delete();
    @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    ev_t e;
    if (!reset && (valid_o || per_err_o)) begin
      n_chk++;
      if (valid_o && per_err_o) begin
        n_fail++;
        $display("FAIL excl: valid_o and per_err_o both high, duty_o=%0d", duty_o);
      end
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event: unexpected valid=%0b per_err=%0b duty=%0d", valid_o, per_err_o, duty_o);
      end else begin
        e = exp_q.pop_front();
        if (e.err != per_err_o || e.duty != duty_o) begin
          n_fail++;
          $display("FAIL event: got per_err=%0b duty=%0d expected per_err=%0b duty=%0d",
                   per_err_o, duty_o, e.err, e.duty);
        end
      end
    end
  end

  initial begin
    int len, h;
    repeat (2) @(negedge clk_i);
    check("init", "rst_outs", int'({duty_o, valid_o, stuck_o, per_err_o}), 0);

    repeat (6) add_per(5, PERIOD);
    run("duty5", 2);

    repeat (3) add_per(5, PERIOD);
    repeat (3) add_per(12, PERIOD);
    run("duty5to12", 2);

    add_const(1'b0, 40);
    repeat (3) add_per(7, PERIOD);
    run("stuck_lo", 3);

    add_const(1'b1, 40);
    run("stuck_hi", 1);

    repeat (4) add_per(9, PERIOD);
    repeat (4) add_per(3, 12);
    run("short_per", 2);

    repeat (2) add_per(6, PERIOD);
    add_const(1'b1, 3);
    run("rst_mid_high", int'($urandom_range(1, 3)));

    repeat (3) add_per(6, PERIOD);
    run("after_rst", 2);

    for (int sc = 0; sc < 6; sc++) begin
      for (int g = 0; g < 8; g++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: add_per(int'($urandom_range(1, 15)), PERIOD);
          3: begin
            len = int'($urandom_range(4, 20));
            add_per(int'($urandom_range(1, len - 1)), len);
          end
          4: add_const(1'($urandom_range(0, 1)), int'($urandom_range(18, 30)));
          default: begin
            h = int'($urandom_range(2, 8));
            add_const(1'b1, h);
            add_const(1'b0, 1);
            add_const(1'b1, 1);
            add_const(1'b0, PERIOD - h - 2);
          end
        endcase
      end
      run("random", int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
